// File: rtl/matrix_scan_ctrl_if.sv
// Pixel-RAM read port and LED-matrix drive signals of matrix_scan_ctrl.
// master = scan controller, slave = RAM/panel side.
interface matrix_scan_ctrl_if;
    logic [12:0] rdaddr_pix_upper;
    logic [12:0] rdaddr_pix_lower;
    logic [3:0]  dout_pix_upper;
    logic [3:0]  dout_pix_lower;
    logic        r1, g1, b1;
    logic        r2, g2, b2;
    logic        sclk;
    logic        lat;
    logic        oe_n;
    logic [2:0]  row_addr;
    logic        frame_done;

    modport master (
        output rdaddr_pix_upper, rdaddr_pix_lower,
        input  dout_pix_upper, dout_pix_lower,
        output r1, g1, b1, r2, g2, b2,
        output sclk, lat, oe_n, row_addr, frame_done
    );

    modport slave (
        input  rdaddr_pix_upper, rdaddr_pix_lower,
        output dout_pix_upper, dout_pix_lower,
        input  r1, g1, b1, r2, g2, b2,
        input  sclk, lat, oe_n, row_addr, frame_done
    );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// HUB-style 1/8-scan LED matrix controller: shifts 32 columns per row from two
// pixel RAMs, blanks, latches, then displays the row for ON_CYCLES cycles.
module matrix_scan_ctrl #(
    parameter int unsigned SHIFT_HALF = 2,
    parameter int unsigned ON_CYCLES  = 256
) (
    input logic                clk,
    input logic                rst,
    input logic                enable,
    matrix_scan_ctrl_if.master pix
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StFetch   = 3'd1;
    localparam logic [2:0] StSetup   = 3'd2;
    localparam logic [2:0] StClkh    = 3'd3;
    localparam logic [2:0] StBlank   = 3'd4;
    localparam logic [2:0] StLatch   = 3'd5;
    localparam logic [2:0] StDisplay = 3'd6;

    localparam logic [15:0] ShLast = 16'(SHIFT_HALF - 1);
    localparam logic [15:0] OnLast = 16'(ON_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [2:0]  row_q, row_d;
    logic [4:0]  col_q, col_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  rgb_up_q, rgb_up_d;
    logic [2:0]  rgb_lo_q, rgb_lo_d;
    logic [2:0]  row_addr_q, row_addr_d;
    logic        idle;
    logic        unused_dout_msb;

    // Bit 3 of each pixel word carries no colour.
    assign unused_dout_msb = pix.dout_pix_upper[3] ^ pix.dout_pix_lower[3];

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        rgb_up_d   = rgb_up_q;
        rgb_lo_d   = rgb_lo_q;
        row_addr_d = row_addr_q;
        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StFetch;
                    col_d   = '0;
                    cnt_d   = '0;
                end
            end
            StFetch: begin
                state_d = StSetup;
                cnt_d   = '0;
            end
            StSetup: begin
                // RAM data for the address shown in FETCH is valid now.
                if (cnt_q == '0) begin
                    rgb_up_d = pix.dout_pix_upper[2:0];
                    rgb_lo_d = pix.dout_pix_lower[2:0];
                end
                if (cnt_q == ShLast) begin
                    cnt_d   = '0;
                    state_d = StClkh;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StClkh: begin
                if (cnt_q == ShLast) begin
                    cnt_d = '0;
                    if (col_q == 5'd31) begin
                        state_d = StBlank;
                    end else begin
                        col_d   = col_q + 5'd1;
                        state_d = StFetch;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StBlank: begin
                state_d    = StLatch;
                row_addr_d = row_q;
            end
            StLatch: begin
                state_d = StDisplay;
                cnt_d   = '0;
            end
            StDisplay: begin
                if (cnt_q == OnLast) begin
                    cnt_d   = '0;
                    row_d   = row_q + 3'd1;
                    col_d   = '0;
                    state_d = enable ? StFetch : StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            row_q      <= '0;
            col_q      <= '0;
            cnt_q      <= '0;
            rgb_up_q   <= '0;
            rgb_lo_q   <= '0;
            row_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            rgb_up_q   <= rgb_up_d;
            rgb_lo_q   <= rgb_lo_d;
            row_addr_q <= row_addr_d;
        end
    end

    // Outputs fall back to their reset values whenever the scanner is idle.
    assign idle = (state_q == StIdle);

    assign pix.rdaddr_pix_upper = (state_q == StFetch) ? {5'b0, row_q, col_q} : 13'd0;
    assign pix.rdaddr_pix_lower = (state_q == StFetch) ? {5'b0, row_q, col_q} : 13'd0;

    assign pix.r1 = rgb_up_q[0] & ~idle;
    assign pix.g1 = rgb_up_q[1] & ~idle;
    assign pix.b1 = rgb_up_q[2] & ~idle;
    assign pix.r2 = rgb_lo_q[0] & ~idle;
    assign pix.g2 = rgb_lo_q[1] & ~idle;
    assign pix.b2 = rgb_lo_q[2] & ~idle;

    assign pix.sclk       = (state_q == StClkh);
    assign pix.lat        = (state_q == StLatch);
    assign pix.oe_n       = (state_q != StDisplay);
    assign pix.row_addr   = idle ? 3'd0 : row_addr_q;
    assign pix.frame_done = (state_q == StDisplay) && (cnt_q == OnLast) && (row_q == 3'd7);

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Randomized bench for matrix_scan_ctrl: two instances (SHIFT_HALF 1 and 3) checked
// every cycle against a row-timeline model built from the scan timing rules.
module tb_matrix_scan_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    bit   chk_on = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    matrix_scan_ctrl_if bus_a ();
    matrix_scan_ctrl_if bus_b ();

    matrix_scan_ctrl #(.SHIFT_HALF(1), .ON_CYCLES(4)) dut_a (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .pix    (bus_a)
    );

    matrix_scan_ctrl #(.SHIFT_HALF(3), .ON_CYCLES(5)) dut_b (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .pix    (bus_b)
    );

    // Shared pixel contents, one-cycle read latency per instance.
    logic [3:0] mem_u [256];
    logic [3:0] mem_l [256];

    always @(posedge clk) begin
        bus_a.dout_pix_upper <= mem_u[bus_a.rdaddr_pix_upper[7:0]];
        bus_a.dout_pix_lower <= mem_l[bus_a.rdaddr_pix_lower[7:0]];
        bus_b.dout_pix_upper <= mem_u[bus_b.rdaddr_pix_upper[7:0]];
        bus_b.dout_pix_lower <= mem_l[bus_b.rdaddr_pix_lower[7:0]];
    end

    // Model: each instance is idle or at cycle offset k of row r.
    int unsigned sh_cfg [2] = '{1, 3};
    int unsigned on_cfg [2] = '{4, 5};
    bit act    [2] = '{0, 0};
    int r_m    [2] = '{0, 0};
    int k_m    [2] = '{0, 0};
    int frames [2] = '{0, 0};
    int fd_cnt [2] = '{0, 0};

    function automatic int row_len(input int i);
        return 32 * (1 + 2 * int'(sh_cfg[i])) + 2 + int'(on_cfg[i]);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                act[i] <= 1'b0;
                r_m[i] <= 0;
                k_m[i] <= 0;
            end else if (!act[i]) begin
                if (enable) begin
                    act[i] <= 1'b1;
                    k_m[i] <= 0;
                end
            end else if (k_m[i] == row_len(i) - 1) begin
                r_m[i] <= (r_m[i] + 1) % 8;
                k_m[i] <= 0;
                act[i] <= enable;
                if (r_m[i] == 7) frames[i] <= frames[i] + 1;
            end else begin
                k_m[i] <= k_m[i] + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ctl packs {sclk, lat, oe_n, frame_done}; colours pack {b,g,r}.
    task automatic check_dut(input int i, input logic [12:0] au, input logic [12:0] al,
                             input logic [2:0] cu, input logic [2:0] cl,
                             input logic [3:0] ctl, input logic [2:0] ra);
        int lc, se, len, c, p, k, r, idx;
        string t;
        t   = (i == 0) ? "a" : "b";
        lc  = 1 + 2 * int'(sh_cfg[i]);
        se  = 32 * lc;
        len = row_len(i);
        k   = k_m[i];
        r   = r_m[i];
        if (!act[i]) begin
            check_eq({t, "_idle_ctl"}, 32'(ctl), 32'(4'b0010));
            check_eq({t, "_idle_addr"}, 32'({au, al}), 32'd0);
            check_eq({t, "_idle_rgb"}, 32'({cu, cl}), 32'd0);
            check_eq({t, "_idle_row_addr"}, 32'(ra), 32'd0);
        end else if (k < se) begin
            c = k / lc;
            p = k % lc;
            idx = r * 32 + c;
            check_eq({t, "_shift_ctl"}, 32'(ctl), {28'd0, (p > int'(sh_cfg[i])), 3'b010});
            check_eq({t, "_addr_u"}, 32'(au), (p == 0) ? 32'(idx) : 32'd0);
            check_eq({t, "_addr_l"}, 32'(al), (p == 0) ? 32'(idx) : 32'd0);
            if (p > int'(sh_cfg[i]))
                check_eq({t, "_rgb"}, 32'({cu, cl}), 32'({mem_u[idx][2:0], mem_l[idx][2:0]}));
        end else if (k == se) begin
            check_eq({t, "_blank_ctl"}, 32'(ctl), 32'(4'b0010));
            check_eq({t, "_blank_addr"}, 32'({au, al}), 32'd0);
        end else if (k == se + 1) begin
            check_eq({t, "_latch_ctl"}, 32'(ctl), 32'(4'b0110));
            check_eq({t, "_latch_row_addr"}, 32'(ra), 32'(r));
        end else begin
            check_eq({t, "_disp_ctl"}, 32'(ctl), {31'd0, (r == 7 && k == len - 1)});
            check_eq({t, "_disp_row_addr"}, 32'(ra), 32'(r));
            check_eq({t, "_disp_addr"}, 32'({au, al}), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check_dut(0, bus_a.rdaddr_pix_upper, bus_a.rdaddr_pix_lower,
                      {bus_a.b1, bus_a.g1, bus_a.r1}, {bus_a.b2, bus_a.g2, bus_a.r2},
                      {bus_a.sclk, bus_a.lat, bus_a.oe_n, bus_a.frame_done}, bus_a.row_addr);
            check_dut(1, bus_b.rdaddr_pix_upper, bus_b.rdaddr_pix_lower,
                      {bus_b.b1, bus_b.g1, bus_b.r1}, {bus_b.b2, bus_b.g2, bus_b.r2},
                      {bus_b.sclk, bus_b.lat, bus_b.oe_n, bus_b.frame_done}, bus_b.row_addr);
            if (bus_a.frame_done === 1'b1) fd_cnt[0]++;
            if (bus_b.frame_done === 1'b1) fd_cnt[1]++;
        end
    end

    task automatic wait_point(input int i, input int row, input int kmin, input int kmax,
                              input string tag);
        int n = 0;
        while (!(act[i] && r_m[i] == row && k_m[i] >= kmin && k_m[i] <= kmax) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check_eq(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((act[0] || act[1]) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check_eq(tag, 32'd0, 32'd1);
    endtask

    initial begin
        rst    = 1'b0;
        enable = 1'b0;
        for (int a = 0; a < 256; a++) begin
            mem_u[a] = 4'h1;
            mem_l[a] = 4'h4;
        end
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        repeat (2) @(negedge clk);

        // Constant pixel data, continuous scan over a full frame of the fast instance.
        rst    = 1'b1;
        enable = 1'b1;
        repeat (8 * 102 + 40) @(negedge clk);

        // Random pixel data with a marked pixel at row 3, col 17.
        rst = 1'b0;
        @(negedge clk);
        for (int a = 0; a < 256; a++) begin
            mem_u[a] = 4'($urandom);
            mem_l[a] = 4'($urandom);
        end
        mem_u[8'h71] = 4'hd;
        mem_l[8'h71] = 4'ha;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        rst = 1'b1;
        repeat (2000) @(negedge clk);

        // Drop enable during col 10 of row 2, then restart after an idle gap.
        wait_point(0, 2, 30, 32, "timeout_row2_col10");
        enable = 1'b0;
        wait_idle("timeout_idle_after_drop");
        repeat ($urandom_range(5, 20)) @(negedge clk);
        enable = 1'b1;
        repeat (2 * 102 + 10) @(negedge clk);

        // Reset during DISPLAY of row 5.
        wait_point(0, 5, 98, 101, "timeout_row5_display");
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_oe_n", 32'(bus_a.oe_n), 32'd1);
        check_eq("rst_sclk_lat_fd", 32'({bus_a.sclk, bus_a.lat, bus_a.frame_done}), 32'd0);
        check_eq("rst_row_addr", 32'(bus_a.row_addr), 32'd0);
        check_eq("rst_addr", 32'({bus_a.rdaddr_pix_upper, bus_a.rdaddr_pix_lower}), 32'd0);
        rst = 1'b1;
        repeat (300) @(negedge clk);

        enable = 1'b0;
        wait_idle("timeout_final_idle");
        repeat (3) @(negedge clk);
        check_eq("frames_a", 32'(fd_cnt[0]), 32'(frames[0]));
        check_eq("frames_b", 32'(fd_cnt[1]), 32'(frames[1]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
